// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a valid/ready word stream and holds the core in reset until done.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing 32-bit wraparound checksum beat, verified before release).
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [DATA_WIDTH-1:0] imem_wdata_o,
  output logic                  core_reset_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_CHECK = 2'd2, ST_RUN = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_RUN = 2'd3} state_t;
`endif

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rel_q, rel_d;
  logic                  error_q, error_d;
  logic                  len_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  match_q, match_d;
`endif

  assign len_ok = (len_i != '0) && (len_i <= MAX_LEN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    error_d = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    acc_d   = acc_q;
    match_d = match_q;
`endif
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start_i) begin
          if (len_ok) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            len_d   = len_i;
            error_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_d   = '0;
`endif
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (s_valid_i) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          // Once all data words are in, the next beat is the expected checksum.
          if (cnt_q == len_q) begin
            match_d = (acc_q == s_data_i);
            state_d = ST_CHECK;
          end else begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_WIDTH-1:0];
            wdata_d = s_data_i;
            cnt_d   = cnt_q + 1'b1;
            acc_d   = acc_q + s_data_i;
          end
`else
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = s_data_i;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = ST_RUN;
          end
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (match_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Release only after a full cycle in RUN so the final write precedes the first fetch.
    rel_d = (state_q == ST_RUN) && (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rel_q   <= 1'b0;
      error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q   <= '0;
      match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rel_q   <= rel_d;
      error_q <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
      match_q <= match_d;
`endif
    end
  end

  assign s_ready_o      = (state_q == ST_LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign busy_o         = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
  assign busy_o         = (state_q == ST_LOAD);
`endif
  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = wdata_q;
  assign core_reset_n_o = rel_q;
  assign done_o         = rel_q;
  assign error_o        = error_q;

endmodule
